mem_bus_fabric: RTL and testbench

Parametrised single-master fabric between the picorv32 native memory port and NUM_SLAVES peripheral targets (SRAM, GPIO, UART, QSPI, and future blocks). It replaces fixed one-hot address-bit decoding with programmable base/mask windows and locks each transaction to one slave. It also returns an error response, instead of hanging the CPU, on an unmapped address or an unresponsive slave. Slaves share the master's mem_addr, mem_wdata and mem_wstrb directly; these are stable for the whole transaction by master protocol.

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_bus_fabric_if.sv | 30 +++
 rtl/mem_bus_addr_decode.sv | 28 ++
 rtl/mem_bus_fabric.sv | 139 +++++++++++++
 tb/tb_mem_bus_fabric.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_fabric shared types and constants.
// FSM states, error codes and default error read data.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DECERR,
        TOERR
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DEC  = 2'b01;
    localparam logic [1:0] ERR_TO   = 2'b10;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_fabric_if.sv
// Master-side and slave-side signals of the memory fabric.
// The fabric modport is the view taken by mem_bus_fabric itself.
interface mem_bus_fabric_if #(
    parameter int NUM_SLAVES = 4
);
    logic                     mem_valid;
    logic [31:0]              mem_addr;
    logic [3:0]               mem_wstrb;
    logic                     mem_ready;
    logic [31:0]              mem_rdata;
    logic [NUM_SLAVES-1:0]    s_valid;
    logic [NUM_SLAVES-1:0]    s_ready;
    logic [NUM_SLAVES*32-1:0] s_rdata;

    modport fabric (
        input  mem_valid, mem_addr, mem_wstrb,
        input  s_ready, s_rdata,
        output mem_ready, mem_rdata, s_valid
    );

    modport master (
        output mem_valid, mem_addr, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  s_valid, mem_addr, mem_wstrb,
        output s_ready, s_rdata
    );
endinterface

// File: rtl/mem_bus_addr_decode.sv
// Base/mask window compare per slave with lowest-index priority.
// Purely combinational so other fabrics can reuse it.
module mem_bus_addr_decode
    import mem_bus_pkg::*;
#(
    parameter int                       NUM_SLAVES = 4,
    parameter int                       SEL_W      = sel_width(NUM_SLAVES),
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = '0
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [SEL_W-1:0] sel
);

    // Scan high to low so the lowest matching index is the last write.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_fabric.sv
// Single-master fabric: windowed decode, per-transaction slave lock,
// decode-error and timeout responses with a sticky error capture.
module mem_bus_fabric
    import mem_bus_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE       = {32'h0040_0000,
                                                          32'h0020_0000,
                                                          32'h0010_0000,
                                                          32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLV_MASK       = {4{32'hFFF0_0000}},
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_fabric_if.fabric   bus,
    input  logic               err_clr,
    output logic               err_irq,
    output logic [1:0]         err_code,
    output logic [31:0]        err_addr
);

    localparam int SEL_W = sel_width(NUM_SLAVES);

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  dec_hit;
    logic [SEL_W-1:0]      dec_sel;
    logic                  cap;
    logic [1:0]            cap_code;
    logic [NUM_SLAVES-1:0] s_valid_d;
    logic                  ready_d;
    logic [31:0]           rdata_d;
    logic                  timeout_hit;

    // Byte strobes only matter to the slaves, which see them directly.
    logic unused_wstrb;
    assign unused_wstrb = ^bus.mem_wstrb;

    mem_bus_addr_decode #(
        .NUM_SLAVES(NUM_SLAVES),
        .SEL_W     (SEL_W),
        .SLV_BASE  (SLV_BASE),
        .SLV_MASK  (SLV_MASK)
    ) u_dec (
        .addr(bus.mem_addr),
        .hit (dec_hit),
        .sel (dec_sel)
    );

    // This ACTIVE cycle is the TIMEOUT_CYCLES-th without completion.
    assign timeout_hit =
        ({1'b0, cnt_q} + 17'd1) >= 17'(TIMEOUT_CYCLES);

    // Next-state and bus outputs; error entry raises a capture request.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        s_valid_d = '0;
        ready_d   = 1'b0;
        rdata_d   = '0;
        cap       = 1'b0;
        cap_code  = ERR_NONE;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    if (dec_hit) begin
                        state_d = ACTIVE;
                        sel_d   = dec_sel;
                        cnt_d   = '0;
                    end else begin
                        state_d  = DECERR;
                        cap      = 1'b1;
                        cap_code = ERR_DEC;
                    end
                end
            end
            ACTIVE: begin
                s_valid_d[sel_q] = 1'b1;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (bus.s_ready[sel_q]) begin
                    ready_d = 1'b1;
                    rdata_d = bus.s_rdata[32*sel_q +: 32];
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d  = TOERR;
                    cap      = 1'b1;
                    cap_code = ERR_TO;
                end
            end
            DECERR, TOERR: begin
                ready_d = 1'b1;
                rdata_d = ERR_RDATA;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_valid   = s_valid_d;
    assign bus.mem_ready = ready_d;
    assign bus.mem_rdata = rdata_d;

    // FSM state, locked slave index and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sticky first-error capture; a clear wins over a same-cycle error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_irq  <= 1'b0;
            err_code <= ERR_NONE;
            err_addr <= '0;
        end else if (err_clr) begin
            err_irq  <= 1'b0;
            err_code <= ERR_NONE;
            err_addr <= '0;
        end else if (cap && !err_irq) begin
            err_irq  <= 1'b1;
            err_code <= cap_code;
            err_addr <= bus.mem_addr;
        end
    end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed table-driven bench for mem_bus_fabric.
// Table of transactions plus hand sequences for multi-cycle corners.
module tb_mem_bus_fabric;
    import mem_bus_pkg::*;

    localparam int NS = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           err_clr = 1'b0;
    logic           err_irq;
    logic [1:0]     err_code;
    logic [31:0]    err_addr;
    logic           auto_rdy = 1'b0;
    logic [NS-1:0]  drv_ready = '0;
    logic [NS*32-1:0] rdv = '0;

    int n_pass = 0;
    int n_total = 0;

    mem_bus_fabric_if #(.NUM_SLAVES(NS)) bus ();

    assign bus.s_ready = auto_rdy ? bus.s_valid : drv_ready;
    assign bus.s_rdata = rdv;

    mem_bus_fabric #(
        .NUM_SLAVES    (NS),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_clr (err_clr),
        .err_irq (err_irq),
        .err_code(err_code),
        .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  ws;
        int          slv;
        int          wt;
        logic [3:0]  noise;
        logic [31:0] data;
        bit          clr;
        logic [3:0]  e_sv;
        int          e_lat;
        logic [31:0] e_rd;
        logic        e_irq;
        logic [1:0]  e_code;
        logic [31:0] e_eaddr;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic set_rdata(input int slv, input logic [31:0] d);
        for (int i = 0; i < NS; i++) rdv[32*i +: 32] = 32'h5A5A_0000 | i;
        if (slv >= 0) rdv[32*slv +: 32] = d;
    endtask

    // Starts at a negedge; wt < 0 means the slave never answers.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] ws,
                           input int wt, input logic [NS-1:0] noise,
                           output int lat, output logic [31:0] rd,
                           output logic [NS-1:0] sv, output int np,
                           output bit rz_bad);
        int  k;
        bit  done;
        lat = 0; rd = '0; sv = '0; np = 0; rz_bad = 0; k = 0; done = 0;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = ws;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            sv |= bus.s_valid;
            if (bus.s_valid != '0) k++;
            if (!done)
                drv_ready = noise |
                    ((wt >= 0 && k == wt + 1) ? bus.s_valid : '0);
            #1;
            if (bus.mem_ready) begin
                np++;
                if (!done) begin
                    lat = c;
                    rd  = bus.mem_rdata;
                    done = 1;
                    @(posedge clk);
                    #1;
                    bus.mem_valid = 1'b0;
                    drv_ready = '0;
                end
            end else if (bus.mem_rdata != '0) begin
                rz_bad = 1;
            end
            if (done && c >= lat + 2) break;
        end
        if (!done) chk("txn_bound", 32'd0, 32'd1);
        bus.mem_valid = 1'b0;
        drv_ready = '0;
    endtask

    initial begin
        int          lat, np;
        logic [31:0] rd;
        logic [NS-1:0] sv;
        bit          rz_bad;

        vt[0] = '{32'h0010_0004, 4'h0, 1,  2, 4'b0000, 32'h1234_5678, 0,
                  4'b0010, 3,  32'h1234_5678, 1'b0, 2'b00, 32'h0};
        vt[1] = '{32'h0000_0010, 4'hF, 0,  0, 4'b1110, 32'h1111_0000, 0,
                  4'b0001, 1,  32'h1111_0000, 1'b0, 2'b00, 32'h0};
        vt[2] = '{32'h8000_0000, 4'h0, -1, -1, 4'b0000, 32'h0, 0,
                  4'b0000, 1,  32'hDEAD_BEEF, 1'b1, 2'b01, 32'h8000_0000};
        vt[3] = '{32'h0040_0100, 4'h0, 3,  1, 4'b0001, 32'hCAFE_F00D, 0,
                  4'b1000, 2,  32'hCAFE_F00D, 1'b1, 2'b01, 32'h8000_0000};
        vt[4] = '{32'h0020_0008, 4'h0, 2, -1, 4'b0011, 32'h0, 0,
                  4'b0100, 17, 32'hDEAD_BEEF, 1'b1, 2'b01, 32'h8000_0000};
        vt[5] = '{32'h0020_000C, 4'h0, 2, -1, 4'b0000, 32'h0, 1,
                  4'b0100, 17, 32'hDEAD_BEEF, 1'b1, 2'b10, 32'h0020_000C};
        vt[6] = '{32'h0020_0010, 4'h0, 2, 15, 4'b0000, 32'h0BAD_F00D, 1,
                  4'b0100, 16, 32'h0BAD_F00D, 1'b0, 2'b00, 32'h0};
        vt[7] = '{32'h0030_0000, 4'h0, -1, -1, 4'b0000, 32'h0, 0,
                  4'b0000, 1,  32'hDEAD_BEEF, 1'b1, 2'b01, 32'h0030_0000};
        vt[8] = '{32'h000F_FFFC, 4'h3, 0,  3, 4'b0000, 32'h7777_8888, 1,
                  4'b0001, 4,  32'h7777_8888, 1'b0, 2'b00, 32'h0};

        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wstrb = '0;
        set_rdata(-1, 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst s_valid", 32'(bus.s_valid), 32'h0);
        chk("rst mem_ready", 32'(bus.mem_ready), 32'h0);
        chk("rst mem_rdata", bus.mem_rdata, 32'h0);
        chk("rst err_irq", 32'(err_irq), 32'h0);
        chk("rst err_code", 32'(err_code), 32'h0);
        chk("rst err_addr", err_addr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            set_rdata(vt[i].slv, vt[i].data);
            if (vt[i].clr) pulse_clr();
            @(negedge clk);
            run_txn(vt[i].addr, vt[i].ws, vt[i].wt, vt[i].noise,
                    lat, rd, sv, np, rz_bad);
            chk($sformatf("v%0d s_valid", i), 32'(sv), 32'(vt[i].e_sv));
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].e_lat));
            chk($sformatf("v%0d rdata", i), rd, vt[i].e_rd);
            chk($sformatf("v%0d pulses", i), 32'(np), 32'd1);
            chk($sformatf("v%0d rdata_idle_zero", i), 32'(rz_bad), 32'd0);
            chk($sformatf("v%0d err_irq", i), 32'(err_irq),
                32'(vt[i].e_irq));
            chk($sformatf("v%0d err_code", i), 32'(err_code),
                32'(vt[i].e_code));
            chk($sformatf("v%0d err_addr", i), err_addr, vt[i].e_eaddr);
        end

        // Back-to-back zero-wait transactions with mem_valid held high.
        rdv[31:0]   = 32'h0101_0101;
        rdv[127:96] = 32'h0303_0303;
        auto_rdy = 1'b1;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_0020;
        bus.mem_wstrb = 4'h0;
        @(negedge clk);
        #1;
        chk("b2b first ready", 32'(bus.mem_ready), 32'd1);
        chk("b2b first rdata", bus.mem_rdata, 32'h0101_0101);
        @(posedge clk);
        #1;
        bus.mem_addr = 32'h0040_0000;
        @(negedge clk);
        chk("b2b decode ready", 32'(bus.mem_ready), 32'd0);
        chk("b2b decode s_valid", 32'(bus.s_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("b2b second s_valid", 32'(bus.s_valid), 32'h8);
        chk("b2b second ready", 32'(bus.mem_ready), 32'd1);
        chk("b2b second rdata", bus.mem_rdata, 32'h0303_0303);
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
        auto_rdy = 1'b0;

        // Clear in the same cycle as a decode-error capture.
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h9000_0000;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("clrcap ready", 32'(bus.mem_ready), 32'd1);
        chk("clrcap rdata", bus.mem_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
        @(negedge clk);
        chk("clrcap err_irq", 32'(err_irq), 32'd0);
        chk("clrcap err_code", 32'(err_code), 32'd0);
        chk("clrcap err_addr", err_addr, 32'h0);

        // Asynchronous reset while a slave transaction is in flight.
        run_txn(32'hA000_0000, 4'h0, -1, '0, lat, rd, sv, np, rz_bad);
        chk("prerst err_irq", 32'(err_irq), 32'd1);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0020_0000;
        repeat (3) @(negedge clk);
        chk("mid s_valid", 32'(bus.s_valid), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst s_valid", 32'(bus.s_valid), 32'h0);
        chk("arst mem_ready", 32'(bus.mem_ready), 32'h0);
        chk("arst err_irq", 32'(err_irq), 32'h0);
        chk("arst err_addr", err_addr, 32'h0);
        bus.mem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_rdata(2, 32'h2468_ACE0);
        @(negedge clk);
        run_txn(32'h0020_0000, 4'h0, 1, '0, lat, rd, sv, np, rz_bad);
        chk("post s_valid", 32'(sv), 32'h4);
        chk("post latency", 32'(lat), 32'd2);
        chk("post rdata", rd, 32'h2468_ACE0);
        chk("post err_irq", 32'(err_irq), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
